// File: rtl/seg7_pkg.sv
// Shared segment codes, slot phases and counter-width helper for the
// multiplexed seven-segment display path.
package seg7_pkg;

  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  // Logical segment patterns, bit6=a ... bit0=g, 1 = lit.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110010;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bus of seg7_scan_driver: frame data in, multiplexed pins out.
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS = 4
) ();

  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz_blank;
  logic [6:0]            seg_out;
  logic                  dp_out;
  logic [DIGITS-1:0]     an_out;
  logic                  frame_done;

  modport master (
    output en, load, bcd_in, dp_in, lz_blank,
    input  seg_out, dp_out, an_out, frame_done
  );

  modport slave (
    input  en, load, bcd_in, dp_in, lz_blank,
    output seg_out, dp_out, an_out, frame_done
  );

endinterface

// File: rtl/seg7_digit_enc.sv
// Combinational BCD to logical seven-segment encoder; codes 10..15 and
// blank_i both give a dark digit.
module seg7_digit_enc
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver: double-buffered frame data,
// per-slot guard interval, leading-zero suppression and pin polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned GUARD          = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned PW = cnt_w(SCAN_DIV);
  localparam int unsigned IW = cnt_w(DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   hold_bcd_q, hold_bcd_d, disp_bcd_q, disp_bcd_d;
  logic [DIGITS-1:0]     hold_dp_q, hold_dp_d, disp_dp_q, disp_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  fd_q, fd_d;

  logic                  slot_end, frame_end, drive, upper_zero;
  logic [DIGITS-1:0]     lz_mask;
  logic [3:0]            cur_bcd;
  logic [6:0]            cur_seg;
  phase_e                phase;

  // Digit k is a leading zero when it and every digit above it are zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (disp_bcd_q[4*k +: 4] == 4'd0);
      lz_mask[k] = upper_zero;
    end
  end

  assign cur_bcd = disp_bcd_q[{idx_q, 2'b00} +: 4];

  seg7_digit_enc u_enc (
    .bcd_i   (cur_bcd),
    .blank_i (bus.lz_blank && lz_mask[idx_q]),
    .seg_o   (cur_seg)
  );

  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    hold_bcd_d = hold_bcd_q;
    hold_dp_d  = hold_dp_q;
    disp_bcd_d = disp_bcd_q;
    disp_dp_d  = disp_dp_q;

    slot_end  = (presc_q == PRESC_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    phase     = (presc_q < GUARD_END) ? PH_GUARD : PH_DRIVE;
    drive     = bus.en && (phase == PH_DRIVE);

    if (bus.load) begin
      hold_bcd_d = bus.bcd_in;
      hold_dp_d  = bus.dp_in;
    end

    // disp samples the pre-load hold value, so a load on the frame-start
    // cycle is deferred to the following frame.
    if (bus.en) begin
      presc_d = slot_end ? '0 : presc_q + 1'b1;
      if (slot_end) idx_d = frame_end ? '0 : idx_q + 1'b1;
      if (frame_end) begin
        disp_bcd_d = hold_bcd_q;
        disp_dp_d  = hold_dp_q;
      end
    end

    seg_d = (drive ? cur_seg : SEG_BLANK) ^ {7{SEG_ACTIVE_LOW}};
    dp_d  = (drive && disp_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
    an_d  = (drive ? (DIGITS'(1) << idx_q) : '0) ^ {DIGITS{AN_ACTIVE_LOW}};
    fd_d  = bus.en && frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      hold_bcd_q <= '0;
      hold_dp_q  <= '0;
      disp_bcd_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= {7{SEG_ACTIVE_LOW}};
      dp_q       <= SEG_ACTIVE_LOW;
      an_q       <= {DIGITS{AN_ACTIVE_LOW}};
      fd_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      hold_bcd_q <= hold_bcd_d;
      hold_dp_q  <= hold_dp_d;
      disp_bcd_q <= disp_bcd_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.an_out     = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-position model checked every cycle plus
// directed literal expectations for each display scenario.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 16;
  localparam int unsigned GUARD    = 2;
  localparam int unsigned FRAME    = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .GUARD          (GUARD),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110010;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Model: one position counter across the whole frame (0..FRAME-1).
  int          pos;
  int          slot, off;
  bit          mvalid = 1'b0;
  bit          zeros, mdrive, mblank;
  logic [3:0]  m_hold [DIGITS];
  logic [3:0]  m_disp [DIGITS];
  logic [DIGITS-1:0] m_hold_dp, m_disp_dp, onehot;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;
  logic [DIGITS-1:0] exp_an;

  always @(posedge clk) begin
    if (rst) begin
      pos = 0;
      for (int k = 0; k < DIGITS; k++) begin
        m_hold[k] = 4'd0;
        m_disp[k] = 4'd0;
      end
      m_hold_dp = '0;
      m_disp_dp = '0;
      exp_seg = 7'b0000000;
      exp_dp  = 1'b0;
      exp_an  = '1;
      exp_fd  = 1'b0;
      mvalid  = 1'b1;
    end else if (mvalid) begin
      slot   = pos / SCAN_DIV;
      off    = pos % SCAN_DIV;
      mdrive = bus.en && (off >= GUARD);
      zeros  = 1'b1;
      for (int k = slot; k < DIGITS; k++)
        if (m_disp[k] != 4'd0) zeros = 1'b0;
      mblank  = bus.lz_blank && (slot > 0) && zeros;
      exp_seg = (mdrive && !mblank) ? enc(m_disp[slot]) : 7'b0000000;
      exp_dp  = mdrive && m_disp_dp[slot];
      onehot  = '0;
      onehot[slot] = 1'b1;
      exp_an  = mdrive ? ~onehot : '1;
      exp_fd  = bus.en && (pos == FRAME - 1);
      if (bus.en && pos == FRAME - 1) begin
        m_disp    = m_hold;
        m_disp_dp = m_hold_dp;
      end
      if (bus.load) begin
        for (int k = 0; k < DIGITS; k++) m_hold[k] = bus.bcd_in[4*k +: 4];
        m_hold_dp = bus.dp_in;
      end
      if (bus.en) pos = (pos + 1) % FRAME;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      checks++;
      if (bus.seg_out !== exp_seg || bus.dp_out !== exp_dp ||
          bus.an_out !== exp_an || bus.frame_done !== exp_fd) begin
        errors++;
        $display("FAIL model t=%0t seg=%b want %b dp=%b want %b an=%b want %b fd=%b want %b",
                 $time, bus.seg_out, exp_seg, bus.dp_out, exp_dp,
                 bus.an_out, exp_an, bus.frame_done, exp_fd);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_an(input logic [DIGITS-1:0] pat, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.an_out !== pat && n < 300);
    chk({name, "_reach"}, 32'(bus.an_out), 32'(pat));
  endtask

  task automatic wait_fd(input int bound, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_done !== 1'b1 && n < bound);
    chk({name, "_fd"}, 32'(bus.frame_done), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] bcd, input logic [3:0] dp);
    bus.bcd_in = bcd;
    bus.dp_in  = dp;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  // segs packed as {slot3, slot2, slot1, slot0}.
  task automatic check_frame(input logic [27:0] segs, input logic [3:0] dps, input string tag);
    logic [3:0] pat;
    for (int k = 0; k < DIGITS; k++) begin
      pat = '1;
      pat[k] = 1'b0;
      wait_an(pat, $sformatf("%s_an%0d", tag, k));
      chk($sformatf("%s_seg%0d", tag, k), 32'(bus.seg_out), 32'(segs[7*k +: 7]));
      chk($sformatf("%s_dp%0d", tag, k), 32'(bus.dp_out), 32'(dps[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, viol;
    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.load     = 1'b0;
    bus.bcd_in   = '0;
    bus.dp_in    = '0;
    bus.lz_blank = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(bus.an_out), 32'h0000000F);
    chk("rst_seg", 32'(bus.seg_out), 32'd0);
    chk("rst_dp", 32'(bus.dp_out), 32'd0);
    chk("rst_fd", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;

    // "   0" after reset
    check_frame({7'b0, 7'b0, 7'b0, 7'b1111110}, 4'b0000, "boot");

    wait_fd(200, "period_a");
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.frame_done !== 1'b1 && cnt < 200);
    chk("fd_period", 32'(cnt), 32'd64);

    do_load(16'h1234, 4'b0100);
    wait_fd(65, "ld1234");
    check_frame({7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0100, "f1234");

    do_load(16'h0070, 4'b0000);
    wait_fd(70, "ld0070");
    check_frame({7'b0, 7'b0, 7'b1110010, 7'b1111110}, 4'b0000, "lz_on");
    bus.lz_blank = 1'b0;
    wait_fd(70, "lzoff");
    check_frame({7'b1111110, 7'b1111110, 7'b1110010, 7'b1111110}, 4'b0000, "lz_off");
    bus.lz_blank = 1'b1;

    do_load(16'hFA09, 4'b0000);
    wait_fd(70, "ldFA09");
    check_frame({7'b0, 7'b0, 7'b1111110, 7'b1111011}, 4'b0000, "fFA09");

    // Load exactly on the frame-start cycle (last cycle of the last slot).
    wait_fd(70, "align");
    repeat (FRAME - 1) @(negedge clk);
    do_load(16'h5678, 4'b0000);
    chk("fd_at_load", 32'(bus.frame_done), 32'd1);
    wait_an(4'b1110, "late_old");
    chk("late_old_seg", 32'(bus.seg_out), 32'(7'b1111011));
    wait_fd(70, "late");
    wait_an(4'b1110, "late_new");
    chk("late_new_seg", 32'(bus.seg_out), 32'(7'b1111111));

    // Disable mid-DRIVE for 100 cycles; a load while dark still lands.
    bus.en = 1'b0;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) begin
        bus.bcd_in = 16'h0001;
        bus.dp_in  = 4'b0000;
        bus.load   = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
      if (bus.an_out !== 4'hF || bus.seg_out !== 7'b0 || bus.frame_done !== 1'b0) viol++;
    end
    chk("dis_dark", 32'(viol), 32'd0);
    bus.en = 1'b1;
    @(negedge clk);
    chk("resume_an", 32'(bus.an_out), 32'(4'b1110));
    wait_fd(70, "dis_ld");
    check_frame({7'b0, 7'b0, 7'b0, 7'b0110000}, 4'b0000, "f0001");

    // Reset during DRIVE of idx 2.
    wait_an(4'b1011, "pre_rst");
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", 32'(bus.an_out), 32'h0000000F);
    chk("mid_rst_seg", 32'(bus.seg_out), 32'd0);
    rst = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.an_out === 4'hF && cnt < 100);
    chk("post_rst_delay", 32'(cnt), 32'(GUARD + 1));
    chk("post_rst_an", 32'(bus.an_out), 32'(4'b1110));
    chk("post_rst_seg", 32'(bus.seg_out), 32'(7'b1111110));

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed N-digit seven-segment display driver for the digital watch display path. It captures a packed BCD word and decimal-point mask, then time-multiplexes the digits onto one shared segment bus with one anode strobe per digit. Features: tear-free frame updates, leading-zero suppression, an anti-ghosting guard interval and configurable output polarity. It sits between the timekeeping counters and the board pins, and replaces per-digit static decoding.

## Interface
- DIGITS, 4, number of multiplexed digits (2..8)
- SCAN_DIV, 1000, clock cycles per digit slot (≥ GUARD+2)
- GUARD, 8, cycles at the start of each slot with all anodes inactive
- SEG_ACTIVE_LOW, 0, 1 = seg_out/dp_out inverted at the pins
- AN_ACTIVE_LOW, 1, 1 = an_out inverted at the pins
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  display enable; 0 = dark, scanning frozen
- load  in  1  one-cycle strobe; captures bcd_in and dp_in
- bcd_in  in  4*DIGITS  digit k at bits [4k+3:4k]; digit 0 is rightmost
- dp_in  in  DIGITS  decimal point per digit
- lz_blank  in  1  1 = suppress leading zeros
- seg_out  out  7  segments, bit6=a … bit0=g
- dp_out  out  1  decimal point of the active digit
- an_out  out  DIGITS  one-hot digit strobe
- frame_done  out  1  one-cycle pulse when the last digit slot ends

## Operation
- Two register stages:
  - hold_bcd/hold_dp are written on load.
  - disp_bcd/disp_dp are copied from hold only at frame start (idx wraps DIGITS-1→0).
  - A frame therefore never mixes old and new values.
- Scan: prescaler counts 0..SCAN_DIV-1. At terminal count it wraps, and idx advances 0→1→…→DIGITS-1→0.
- Slot phases, driven by the prescaler:
  - GUARD (prescaler < GUARD): an_out all inactive, seg_out blank.
  - DRIVE (remaining cycles): an_out[idx] active, seg_out/dp_out show digit idx.
- Encoding (logical, before polarity):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110010, 8=1111111, 9=1111011
  - 10..15 → 0000000 (blank)
- Leading-zero suppression (lz_blank=1):
  - Digit k>0 is blanked if disp_bcd digits k..DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - The dp of a suppressed digit is still shown.
- Polarity is applied last, on registered outputs.
- en=0: prescaler and idx hold, an_out inactive, seg_out/dp_out blank, frame_done 0. Loads are still accepted into hold.
- en 0→1: the current slot resumes from the held prescaler value.

## Timing
- All outputs are registered: seg_out/an_out/dp_out reflect the prescaler/idx state one cycle later.
- Reset values (logical):
  - prescaler=0, idx=0, hold/disp=0, frame_done=0
  - an_out all inactive, seg_out=0000000, dp_out=0
  - Pin levels follow the polarity parameters.
- After reset with lz_blank=1: display shows "   0" from the first DRIVE phase.
- Load to display: a load at cycle t appears at the first frame start after t+1, no later than DIGITS·SCAN_DIV+1 cycles.
- Load coinciding with the frame-start cycle: hold updates, but disp takes the previous hold value. The new value waits one frame.
- Back-to-back loads: the last load before frame start wins.
- frame_done is asserted in the cycle the prescaler hits terminal count with idx=DIGITS-1. This is the same edge disp is reloaded.
- rst mid-slot: all state returns to reset values on the next edge, and an_out goes inactive immediately after that edge.
- Refresh period = DIGITS·SCAN_DIV cycles. Anode duty = (SCAN_DIV-GUARD)/(DIGITS·SCAN_DIV).

## Structure
- Package seg7_pkg:
  - logical segment constants SEG_0..SEG_9 and SEG_BLANK
  - function/localparam widths for the prescaler ($clog2(SCAN_DIV)) and idx ($clog2(DIGITS))
- Sub-module seg7_digit_enc: combinational 4-bit → 7-bit logical encoder with a blank input. Instantiated once, on the muxed disp digit.
- Top holds the prescaler, idx, hold/disp registers, lz mask logic, polarity stage and output registers.

## Test plan
- Reset, DIGITS=4, SCAN_DIV=16, GUARD=2, lz_blank=1:
  - an_out steps through 1110,1101,1011,0111 (AN_ACTIVE_LOW).
  - Digit 0 seg_out=1111110; digits 1–3 blank.
  - frame_done every 64 cycles.
- load bcd_in=16'h1234, dp_in=4'b0100 → within ≤65 cycles, frames show 4,3,2,1 on idx 0..3 with dp_out=1 only on idx 2. An old/new mixed frame never occurs.
- bcd_in=16'h0070, lz_blank=1 → digits 3,2 blank, digit 1=1110010, digit 0=1111110. With lz_blank=0, digits 3,2 show 1111110.
- bcd_in=16'hFA09 → digits 3,2 blank (invalid code), digit 1=1111110, digit 0=1111011.
- Load on the exact frame_done cycle → the new value first appears one frame later. With en=0 for 100 cycles, an_out stays inactive and idx/prescaler are unchanged on re-enable.
- Assert rst during the DRIVE phase of idx=2 → next cycle an_out inactive and seg_out blank. The next active slot is idx 0 after GUARD cycles.
